// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: stall vectors,
// state encodings and default redirect addresses.
package pipe_ctrl_pkg;

  localparam logic [31:0] ZeroWord           = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

  // Hold bits: [0] pc, [1] if/id, [2] id/ex, [3] ex/mem, [4] mem/wb, [5] wb
  localparam logic [5:0] STALL_NONE     = 6'b000000;
  localparam logic [5:0] STALL_FROM_ID  = 6'b000111;
  localparam logic [5:0] STALL_FROM_EX  = 6'b001111;
  localparam logic [5:0] STALL_FROM_MEM = 6'b011111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_t;

  // Later stages win: holding mem also has to hold everything upstream of it.
  function automatic logic [5:0] stall_encode(input logic req_id,
                                              input logic req_ex,
                                              input logic req_mem);
    if (req_mem)     return STALL_FROM_MEM;
    else if (req_ex) return STALL_FROM_EX;
    else if (req_id) return STALL_FROM_ID;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Consecutive-stall watchdog: saturating counter of back-to-back stalled
// cycles and a flag that stays set until reset once the limit is reached.
module pipe_ctrl_wdog #(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_active,
  output logic timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STALL_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(STALL_TIMEOUT - 1);

  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      if (!stall_active)
        stall_cnt <= '0;
      else if (stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;

      if (stall_active && (stall_cnt == CNT_TRIP))
        timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Define PIPE_CTRL_PERF_EN to add stall-cycle and flush-count performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEFAULT,
  parameter int          STALL_TIMEOUT = 1024,
  parameter int          CNT_W         = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        excp_valid_i,
  input  logic        excp_eret_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_timeout_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [15:0] flush_count_o
`endif
);

  ctrl_state_t state, state_nxt;
  logic        any_req;

  assign any_req = stallreq_id_i | stallreq_ex_i | stallreq_mem_i;

  // Outputs are combinational so a request holds the pipe on the same edge.
  // Reset masks them, so nothing leaks out while the state is being cleared.
  always_comb begin
    stall_o   = STALL_NONE;
    flush_o   = 1'b0;
    new_pc_o  = ZeroWord;
    state_nxt = state;
    if (!rst) begin
      unique case (state)
        RUN, STALL: begin
          if (excp_valid_i) begin
            flush_o   = 1'b1;
            state_nxt = FLUSH;
          end else if (any_req) begin
            stall_o   = stall_encode(stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
            state_nxt = STALL;
          end else begin
            state_nxt = RUN;
          end
        end
        FLUSH:   state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
      if (flush_o)
        new_pc_o = excp_eret_i ? cp0_epc_i : EXC_VECTOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  pipe_ctrl_wdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT),
    .CNT_W        (CNT_W)
  ) u_wdog (
    .clk         (clk),
    .rst         (rst),
    .stall_active(|stall_o),
    .timeout     (stall_timeout_o)
  );

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      if (|stall_o)
        stall_cycles_o <= stall_cycles_o + 32'd1;
      if (flush_o && (flush_count_o != 16'hFFFF))
        flush_count_o <= flush_count_o + 16'd1;
    end
  end
`endif

endmodule
